muldiv_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide engine and its sequencing controller, placed in the execute stage beside the ALU. It takes M-extension operations off the single-cycle ALU path. It accepts one operation through a valid/ready handshake and runs a 32-iteration shift-add or restoring-divide loop. It holds the result until the consumer takes it, and drives a busy/stall signal to the pipeline hazard logic.

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer_if
//  Description : Request/response bundle between the execute stage and the
//                multi-cycle RV32M multiply/divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_operand1;
  logic [XLEN-1:0] req_operand2;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  // Execute-stage side: issues operations and consumes results.
  modport master (
    output flush, req_valid, req_op, req_operand1, req_operand2, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, req_valid, req_op, req_operand1, req_operand2, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : RV32M multiply/divide engine. Shift-add multiply and
//                restoring divide on operand magnitudes, one bit per cycle,
//                followed by a single sign-fix cycle. Divide-by-zero and
//                signed overflow bypass the loop.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN       = 32,
  parameter int ITERATIONS = 32
) (
  input wire              clk,
  input wire              rst_n,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [5:0]      c_LAST    = 6'(ITERATIONS - 1);
  localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] c_ZERO    = {XLEN{1'b0}};

  state_t            r_state;
  logic [2:0]        r_op;
  logic              r_neg;       // product/quotient must be negated
  logic              r_rem_neg;   // remainder takes the dividend's sign
  logic [2*XLEN-1:0] r_a;         // multiplicand, shifted left each step
  logic [XLEN-1:0]   r_b;         // multiplier (shifted right) or divisor
  logic [2*XLEN-1:0] r_acc;       // MUL: product; DIV: {remainder, quotient}
  logic [5:0]        r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_resp_valid;
  logic              r_req_ready;
  logic              r_busy;

  // Request decode: operand signedness by funct3, magnitudes, special cases.
  logic [2:0]      w_op;
  logic            w_s1, w_s2, w_n1, w_n2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_ovf, w_div0, w_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_op   = bus.req_op;
  assign w_s1   = (w_op == 3'd0) || (w_op == 3'd1) || (w_op == 3'd2) ||
                  (w_op == 3'd4) || (w_op == 3'd6);
  assign w_s2   = (w_op == 3'd0) || (w_op == 3'd1) ||
                  (w_op == 3'd4) || (w_op == 3'd6);
  assign w_n1   = w_s1 && bus.req_operand1[XLEN-1];
  assign w_n2   = w_s2 && bus.req_operand2[XLEN-1];
  assign w_mag1 = w_n1 ? -bus.req_operand1 : bus.req_operand1;
  assign w_mag2 = w_n2 ? -bus.req_operand2 : bus.req_operand2;
  assign w_div0 = (bus.req_operand2 == c_ZERO);
  assign w_ovf  = ((w_op == 3'd4) || (w_op == 3'd6)) &&
                  (bus.req_operand1 == c_INT_MIN) && (bus.req_operand2 == c_ONES);
  assign w_special = w_op[2] && (w_div0 || w_ovf);
  // op[1] separates remainder ops (REM/REMU) from quotient ops (DIV/DIVU).
  assign w_spec_res = w_div0 ? (w_op[1] ? bus.req_operand1 : c_ONES)
                             : (w_op[1] ? c_ZERO : c_INT_MIN);

  // One shift-add step.
  logic [2*XLEN-1:0] w_mul_acc;
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : {(2*XLEN){1'b0}});

  // One restoring-divide step: shift {rem, quo} left, try subtracting divisor.
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_acc;
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  // The true difference is below the divisor, so the low XLEN bits suffice.
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_b;
  assign w_div_acc   = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                                : {r_acc[2*XLEN-2:0], 1'b0};

  // Sign fix and result selection.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_rem_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Result mux keyed on the latched funct3.
  always_comb begin
    w_fix_res = c_ZERO;
    case (r_op)
      3'd0:                 w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:     w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:           w_fix_res = w_quo;
      default:              w_fix_res = w_rem;
    endcase
  end

  // Sequencer FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_neg        <= 1'b0;
      r_rem_neg    <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= 6'd0;
      r_result     <= '0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else if (bus.flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_op        <= w_op;
            r_neg       <= w_n1 ^ w_n2;
            r_rem_neg   <= w_n1;
            r_a         <= {c_ZERO, w_mag1};
            r_b         <= w_mag2;
            r_acc       <= w_op[2] ? {c_ZERO, w_mag1} : {(2*XLEN){1'b0}};
            r_cnt       <= 6'd0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            if (!w_op[2]) begin
              r_state <= S_MUL;
            end else if (w_special) begin
              // Result is known now; valid follows on the next edge in DONE.
              r_result <= w_spec_res;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          if (r_cnt == c_LAST) r_state <= S_FIX;
          else                 r_cnt   <= r_cnt + 6'd1;
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          if (r_cnt == c_LAST) r_state <= S_FIX;
          else                 r_cnt   <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_result     <= w_fix_res;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (r_resp_valid && bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_result;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Directed self-checking bench for muldiv_sequencer. A
//                timeline model (op outstanding, cycles left, arithmetic
//                result) is compared against the DUT every cycle, and
//                directed vectors carry hand-computed results and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   t_acc    = 0;
  bit   chk_en   = 1'b0;

  muldiv_sequencer_if bus_if ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Architectural RV32M result computed with plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    p  = 64'd0;
    case (op)
      3'd0, 3'd1: p = 64'(longint'(sa) * longint'(sb));
      3'd2:       p = 64'(longint'(sa) * longint'({32'd0, b}));
      3'd3:       p = {32'd0, a} * {32'd0, b};
      default:    p = 64'd0;
    endcase
    if (op == 3'd0) return p[31:0];
    if (op <= 3'd3) return p[63:32];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      3'd4:    return 32'(sa / sb);
      3'd5:    return a / b;
      3'd6:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 32'd0 ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timeline model: which cycle the result appears and when it is consumed.
  bit          m_active = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_result = 32'd0;

  always @(posedge clk) begin
    if (!rst_n || bus_if.flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (bus_if.req_valid) begin
        m_active <= 1'b1;
        m_left   <= is_special(bus_if.req_op, bus_if.req_operand1, bus_if.req_operand2) ? 1 : 33;
        m_result <= ref_result(bus_if.req_op, bus_if.req_operand1, bus_if.req_operand2);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (bus_if.resp_ready) begin
      m_active <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       32'(bus_if.busy),       32'(m_active));
      chk("req_ready",  32'(bus_if.req_ready),  32'(!m_active));
      chk("resp_valid", 32'(bus_if.resp_valid), 32'(m_active && m_left == 0));
      if (m_active && m_left == 0)
        chk("resp_result", bus_if.resp_result, m_result);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.req_valid    = 1'b1;
    bus_if.req_op       = op;
    bus_if.req_operand1 = a;
    bus_if.req_operand2 = b;
    @(posedge clk);
    #1;
    t_acc = cyc;
    bus_if.req_valid = 1'b0;
  endtask

  // Issue, wait for the result with a bound, hold off the consumer, take it.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    bit seen;
    seen = 1'b0;
    issue(op, a, b);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) seen = 1'b1;
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_latency"}, 32'(cyc - t_acc), 32'(lat));
      chk({nm, "_result"}, bus_if.resp_result, exp);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({nm, "_hold_result"}, bus_if.resp_result, exp);
        chk({nm, "_hold_busy"}, 32'(bus_if.busy), 32'd1);
        chk({nm, "_hold_ready"}, 32'(bus_if.req_ready), 32'd0);
      end
      bus_if.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.resp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
    '{3'd4, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1},
    '{3'd6, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
    '{3'd5, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1},
    '{3'd7, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
    '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33},
    '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33},
    '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33},
    '{3'd7, 32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 33},
    '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33},
    '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33}
  };

  initial begin
    int vcount;
    rst_n               = 1'b0;
    bus_if.flush        = 1'b0;
    bus_if.req_valid    = 1'b0;
    bus_if.req_op       = 3'd0;
    bus_if.req_operand1 = 32'd0;
    bus_if.req_operand2 = 32'd0;
    bus_if.resp_ready   = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset held two cycles in the middle of a divide.
    issue(3'd5, 32'h0000_03E8, 32'h0000_0007);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready",  32'(bus_if.req_ready),  32'd1);
    chk("rst_busy",       32'(bus_if.busy),       32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_result",     bus_if.resp_result,     32'd0);
    @(posedge clk);
    #1;

    // Directed vectors.
    vcount = 0;
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", vcount), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, 0);
      vcount++;
    end

    // Flush ten cycles into a multiply: no response may ever appear.
    issue(3'd0, 32'h0000_0007, 32'h0000_0003);
    repeat (9) @(posedge clk);
    #1;
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",      32'(bus_if.busy),      32'd0);
    chk("flush_req_ready", 32'(bus_if.req_ready), 32'd1);
    begin
      int hits;
      hits = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus_if.resp_valid) hits++;
      end
      chk("flush_no_resp", 32'(hits), 32'd0);
    end
    @(posedge clk);
    #1;

    // Flush together with a request in IDLE blocks the accept.
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 3'd0;
    bus_if.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    bus_if.flush     = 1'b0;
    @(negedge clk);
    chk("flush_accept_blocked", 32'(bus_if.busy), 32'd0);
    @(posedge clk);
    #1;

    // Consumer stalls five cycles in DONE.
    run_op("stall", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5);
    run_op("after_stall", 3'd4, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1, 2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
